// File: rtl/attention_score_unit.sv
// Scaled dot-product score engine: latches one query vector, streams keys, and emits
// sat((q.k) >>> SCALE_SHIFT) per key on a valid/ready stream while tracking the running max.
module attention_score_unit #(
  parameter int HEAD_DIM    = 64,
  parameter int LANES       = 8,
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 40,
  parameter int OUT_W       = 32,
  parameter int MAX_TOKENS  = 128,
  parameter int SCALE_SHIFT = 3,
  localparam int BEATS      = HEAD_DIM / LANES,
  localparam int LEN_W      = $clog2(MAX_TOKENS) + 1,
  localparam int IDX_W      = $clog2(MAX_TOKENS),
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          seq_len,
  output logic                      busy,
  output logic                      done,
  input  logic                      q_valid,
  output logic                      q_ready,
  input  logic [LANES*DATA_W-1:0]   q_data,
  input  logic                      k_valid,
  output logic                      k_ready,
  input  logic [LANES*DATA_W-1:0]   k_data,
  output logic                      s_valid,
  input  logic                      s_ready,
  output logic [OUT_W-1:0]          s_data,
  output logic [IDX_W-1:0]          s_idx,
  output logic                      s_last,
  output logic [OUT_W-1:0]          max_score,
  output logic                      max_valid
);

  typedef enum logic [2:0] {IDLE, LOAD_Q, ACC_K, EMIT, DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                     state, state_next;
  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           len_clamped;
  logic [IDX_W-1:0]           key_idx;
  logic [BEAT_W-1:0]          beat_cnt;
  logic                       beat_last;
  logic [LANES*DATA_W-1:0]    q_buffer [BEATS];
  logic [LANES*DATA_W-1:0]    q_cur;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    lane_sum;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [2*DATA_W-1:0] prod;
  logic [OUT_W-1:0]           score_sat;
  logic                       q_fire, k_fire, s_fire;

  assign len_clamped = (seq_len > LEN_W'(MAX_TOKENS)) ? LEN_W'(MAX_TOKENS) : seq_len;
  assign beat_last   = (beat_cnt == BEAT_W'(BEATS - 1));
  assign q_cur       = q_buffer[beat_cnt];
  assign q_fire      = q_valid && q_ready;
  assign k_fire      = k_valid && k_ready;
  assign s_fire      = s_valid && s_ready;
  assign s_idx       = key_idx;

  // NOTE: sequential state uses <= only, so every branch reads the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    q_ready    = 1'b0;
    k_ready    = 1'b0;
    s_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (len_clamped == '0) ? DONE : LOAD_Q;
      end
      LOAD_Q: begin
        q_ready = 1'b1;
        if (q_valid && beat_last) state_next = ACC_K;
      end
      ACC_K: begin
        k_ready = 1'b1;
        if (k_valid && beat_last) state_next = EMIT;
      end
      EMIT: begin
        s_valid = 1'b1;
        if (s_ready) state_next = s_last ? DONE : ACC_K;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One key beat: LANES full-precision signed products summed into the accumulator.
  always_comb begin
    prod     = '0;
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod     = $signed(q_cur[i*DATA_W +: DATA_W]) * $signed(k_data[i*DATA_W +: DATA_W]);
      lane_sum = lane_sum + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
    acc_next = acc + lane_sum;
    shifted  = acc_next >>> SCALE_SHIFT;
    if (shifted > SAT_HI)      score_sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (shifted < SAT_LO) score_sat = {1'b1, {(OUT_W-1){1'b0}}};
    else                       score_sat = shifted[OUT_W-1:0];
  end

  // NOTE: q_buffer is flop-based and cleared on reset so no stale query survives an aborted run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      key_idx   <= '0;
      beat_cnt  <= '0;
      acc       <= '0;
      s_data    <= '0;
      s_last    <= 1'b0;
      max_score <= '0;
      max_valid <= 1'b0;
      for (int b = 0; b < BEATS; b++) q_buffer[b] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q     <= len_clamped;
            max_valid <= 1'b0;
            key_idx   <= '0;
            beat_cnt  <= '0;
          end
        end
        LOAD_Q: begin
          if (q_fire) begin
            q_buffer[beat_cnt] <= q_data;
            if (beat_last) begin
              beat_cnt <= '0;
              acc      <= '0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        ACC_K: begin
          if (k_fire) begin
            acc <= acc_next;
            if (beat_last) begin
              s_data <= score_sat;
              s_last <= ({1'b0, key_idx} == len_q - LEN_W'(1));
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        EMIT: begin
          if (s_fire) begin
            if (!max_valid || $signed(s_data) > $signed(max_score)) max_score <= s_data;
            max_valid <= 1'b1;
            if (!s_last) begin
              key_idx  <= key_idx + IDX_W'(1);
              acc      <= '0;
              beat_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_attention_score_unit.sv
// Directed-plus-random bench for attention_score_unit; scores are predicted from plain
// dot-product arithmetic with floor division and clamping.
module tb_attention_score_unit;

  localparam int HEAD_DIM   = 64;
  localparam int LANES      = 8;
  localparam int DATA_W     = 16;
  localparam int OUT_W      = 32;
  localparam int MAX_TOKENS = 128;
  localparam int BEATS      = HEAD_DIM / LANES;
  localparam longint SMAX   = (64'sd1 <<< 31) - 1;
  localparam longint SMIN   = -(64'sd1 <<< 31);

  logic                    clk, rst_n, start;
  logic [7:0]              seq_len;
  logic                    busy, done;
  logic                    q_valid, q_ready, k_valid, k_ready;
  logic [LANES*DATA_W-1:0] q_data, k_data;
  logic                    s_valid, s_ready, s_last, max_valid;
  logic [OUT_W-1:0]        s_data, max_score;
  logic [6:0]              s_idx;

  int     checks = 0;
  int     failures = 0;
  int     qv [HEAD_DIM];
  int     kv [HEAD_DIM];
  longint m_max;
  bit     m_valid;
  int     cnt_done, cnt_q, cnt_s, cnt_busy;
  int     scores4 [4] = '{5, -3, 12, 7};

  attention_score_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_len(seq_len),
    .busy(busy), .done(done),
    .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_idx(s_idx), .s_last(s_last),
    .max_score(max_score), .max_valid(max_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_score();
    longint dot = 0;
    longint fl;
    for (int i = 0; i < HEAD_DIM; i++) dot += longint'(qv[i]) * longint'(kv[i]);
    fl = dot / 8;
    if (dot < 0 && dot % 8 != 0) fl -= 1;
    if (fl > SMAX) fl = SMAX;
    if (fl < SMIN) fl = SMIN;
    return fl;
  endfunction

  function automatic int rand_elem();
    return int'($signed(16'($urandom)));
  endfunction

  task automatic fill_q(input int v);
    for (int i = 0; i < HEAD_DIM; i++) qv[i] = v;
  endtask

  task automatic fill_k(input int v);
    for (int i = 0; i < HEAD_DIM; i++) kv[i] = v;
  endtask

  task automatic rand_q();
    for (int i = 0; i < HEAD_DIM; i++) qv[i] = rand_elem();
  endtask

  task automatic rand_k();
    for (int i = 0; i < HEAD_DIM; i++) kv[i] = rand_elem();
  endtask

  task automatic start_run(input int len);
    start   = 1'b1;
    seq_len = 8'(len);
    m_valid = 1'b0;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic send_query();
    for (int b = 0; b < BEATS; b++) begin
      q_valid = 1'b1;
      for (int l = 0; l < LANES; l++) q_data[l*DATA_W +: DATA_W] = 16'(qv[b*LANES + l]);
      for (int n = 0; n < 50 && !q_ready; n++) @(negedge clk);
      check("q_ready", q_ready, 1);
      check("k_ready_excl", k_ready, 0);
      @(negedge clk);
    end
    q_valid = 1'b0;
  endtask

  task automatic send_key(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      k_valid = 1'b1;
      for (int l = 0; l < LANES; l++) k_data[l*DATA_W +: DATA_W] = 16'(kv[b*LANES + l]);
      for (int n = 0; n < 50 && !k_ready; n++) @(negedge clk);
      check("k_ready", k_ready, 1);
      check("q_ready_excl", q_ready, 0);
      @(negedge clk);
    end
    k_valid = 1'b0;
    if (nbeats == BEATS) check("s_latency", s_valid, 1);
  endtask

  task automatic recv_score(input int idx, input bit last);
    longint sc;
    sc = exp_score();
    for (int n = 0; n < 50 && !s_valid; n++) @(negedge clk);
    check("s_valid", s_valid, 1);
    check("s_data", $signed(s_data), sc);
    check("s_idx", s_idx, idx);
    check("s_last", s_last, last);
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    if (!m_valid || sc > m_max) m_max = sc;
    m_valid = 1'b1;
  endtask

  task automatic check_done();
    check("done_pulse", done, 1);
    check("max_score", $signed(max_score), m_max);
    check("max_valid", max_valid, 1);
    @(negedge clk);
    check("done_low", done, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic run_single();
    start_run(1);
    send_query();
    send_key(BEATS);
    recv_score(0, 1'b1);
    check_done();
  endtask

  task automatic run_random(input int len_req, input int len_eff);
    start_run(len_req);
    rand_q();
    send_query();
    for (int k = 0; k < len_eff; k++) begin
      rand_k();
      send_key(BEATS);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      recv_score(k, k == len_eff - 1);
    end
    check_done();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_q_ready"}, q_ready, 0);
    check({tag, "_k_ready"}, k_ready, 0);
    check({tag, "_s_valid"}, s_valid, 0);
    check({tag, "_s_data"}, s_data, 0);
    check({tag, "_s_idx"}, s_idx, 0);
    check({tag, "_s_last"}, s_last, 0);
    check({tag, "_max_score"}, max_score, 0);
    check({tag, "_max_valid"}, max_valid, 0);
  endtask

  initial begin
    clk = 0; rst_n = 0; start = 0; seq_len = 0;
    q_valid = 0; q_data = '0; k_valid = 0; k_data = '0; s_ready = 0;
    m_max = 0; m_valid = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Unit-valued vectors: +1 x +2 gives 16, +1 x -1 floors to -8.
    fill_q(1); fill_k(2);
    run_single();
    fill_q(1); fill_k(-1);
    run_single();

    // Saturation at both rails.
    fill_q(32767); fill_k(32767);
    run_single();
    fill_k(-32767);
    run_single();

    // Four keys against one held query, known scores 5,-3,12,7.
    start_run(4);
    fill_q(1);
    send_query();
    for (int k = 0; k < 4; k++) begin
      fill_k(0);
      kv[0] = 8 * scores4[k];
      send_key(BEATS);
      recv_score(k, k == 3);
    end
    check("max_is_12", $signed(max_score), 12);
    check_done();

    // Backpressure: score held and keys refused while s_ready stays low.
    start_run(1);
    rand_q();
    send_query();
    rand_k();
    send_key(BEATS);
    k_valid = 1'b1;
    k_data  = {LANES{16'h1234}};
    repeat (5) begin
      check("bp_s_data", $signed(s_data), exp_score());
      check("bp_s_idx", s_idx, 0);
      check("bp_k_ready", k_ready, 0);
      check("bp_s_valid", s_valid, 1);
      @(negedge clk);
    end
    k_valid = 1'b0;
    recv_score(0, 1'b1);
    check_done();

    // Random multi-key runs, then an over-length request clamped to MAX_TOKENS.
    for (int r = 0; r < 4; r++) begin
      automatic int len = $urandom_range(2, 5);
      run_random(len, len);
    end
    run_random(200, MAX_TOKENS);

    // Zero-length run goes straight to DONE.
    start_run(0);
    cnt_done = 0; cnt_q = 0; cnt_s = 0;
    for (int n = 0; n < 4; n++) begin
      cnt_done += int'(done);
      cnt_q    += int'(q_ready);
      cnt_s    += int'(s_valid);
      @(negedge clk);
    end
    check("zero_len_done_count", cnt_done, 1);
    check("zero_len_q_ready", cnt_q, 0);
    check("zero_len_s_valid", cnt_s, 0);
    check("zero_len_max_valid", max_valid, 0);
    check("zero_len_busy", busy, 0);

    // Reset in the middle of a key accumulation aborts the run.
    start_run(2);
    rand_q();
    send_query();
    rand_k();
    send_key(3);
    check("pre_reset_k_ready", k_ready, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0; cnt_busy = 0;
    repeat (3) begin
      cnt_done += int'(done);
      cnt_busy += int'(busy);
      @(negedge clk);
    end
    check("post_reset_done", cnt_done, 0);
    check("post_reset_busy", cnt_busy, 0);

    // Recovery after the abort.
    fill_q(1); fill_k(2);
    run_single();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
